// File: rtl/ultrasonic_ctrl_mc.sv
// ultrasonic_ctrl_mc
//   Multi-channel DAC drive controller with receive-sample capture buffer.
//   - NCH independent channels, each with an on/off flag and a saturating
//     DAC level, updated through a single valid/ready command port.
//   - Any accepted command with cmd_capture=1 (re)starts a capture of rec_en
//     qualified samples into a DATA_W x DEPTH buffer. RING_MODE=0 stops when
//     full, RING_MODE=1 overwrites the oldest entry and flags overflow.
//   - Registered read port (one-cycle latency, read-first on collisions).
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_op/
//   cmd_ch/cmd_amount/cmd_capture command port (ready always 1)
//   dac_out, dac_on               per-channel DAC level and enable
//   rec_en, buf_in                receive sample input
//   capturing, cap_done, cap_ch,
//   cap_count, cap_start, overflow capture status
//   rd_en, rd_add, rd_data,
//   rd_valid                      buffer read port
module ultrasonic_ctrl_mc #(
  parameter int NCH       = 4,
  parameter int CH_W      = 2,
  parameter int DAC_W     = 12,
  parameter int DATA_W    = 25,
  parameter int DEPTH     = 128,
  parameter int ADDR_W    = 7,
  parameter int RING_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [CH_W-1:0]        cmd_ch,
  input  logic [7:0]             cmd_amount,
  input  logic                   cmd_capture,
  output logic [NCH*DAC_W-1:0]   dac_out,
  output logic [NCH-1:0]         dac_on,
  input  logic                   rec_en,
  input  logic [DATA_W-1:0]      buf_in,
  output logic                   capturing,
  output logic                   cap_done,
  output logic [CH_W-1:0]        cap_ch,
  output logic [ADDR_W:0]        cap_count,
  output logic [ADDR_W-1:0]      cap_start,
  output logic                   overflow,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      rd_add,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid
);

  localparam logic [2:0] OP_ON   = 3'd1;
  localparam logic [2:0] OP_OFF  = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_DEC  = 3'd4;
  localparam logic [2:0] OP_SET  = 3'd5;
  localparam logic [2:0] OP_STOP = 3'd6;

  localparam logic [ADDR_W:0] CNT_MAX  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_LAST = CNT_MAX - 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  state_t state_q, state_d;

  logic                accept, start, stop, wr;
  logic [DAC_W-1:0]    level [NCH];
  logic [DAC_W-1:0]    amt_ext, cur_lvl, new_lvl;
  logic [DAC_W:0]      sum, diff;
  logic                lvl_we;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign cmd_ready = 1'b1;
  assign accept    = cmd_valid & cmd_ready;
  assign start     = accept & cmd_capture;
  assign stop      = accept & (cmd_op == OP_STOP);
  // A capture start owns its cycle: the concurrent sample is discarded.
  assign wr        = (state_q == S_CAPTURE) & rec_en & ~start;
  assign amt_ext   = DAC_W'(cmd_amount);

  // Level arithmetic for the addressed channel, one extra bit to detect
  // carry/borrow so results clamp instead of wrapping.
  always_comb begin
    cur_lvl = '0;
    for (int unsigned i = 0; i < NCH; i++)
      if (cmd_ch == CH_W'(i)) cur_lvl = level[i];
    sum     = {1'b0, cur_lvl} + {1'b0, amt_ext};
    diff    = {1'b0, cur_lvl} - {1'b0, amt_ext};
    new_lvl = cur_lvl;
    lvl_we  = 1'b0;
    if (accept) begin
      case (cmd_op)
        OP_INC: begin lvl_we = 1'b1; new_lvl = sum[DAC_W]  ? '1 : sum[DAC_W-1:0];  end
        OP_DEC: begin lvl_we = 1'b1; new_lvl = diff[DAC_W] ? '0 : diff[DAC_W-1:0]; end
        OP_SET: begin lvl_we = 1'b1; new_lvl = amt_ext; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCH; i++) level[i] <= '0;
      dac_on <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (cmd_ch == CH_W'(i)) begin
          if (lvl_we) level[i] <= new_lvl;
          if (accept && cmd_op == OP_ON)  dac_on[i] <= 1'b1;
          if (accept && cmd_op == OP_OFF) dac_on[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    dac_out = '0;
    for (int unsigned i = 0; i < NCH; i++)
      dac_out[i*DAC_W +: DAC_W] = dac_on[i] ? level[i] : '0;
  end

  // Capture FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_CAPTURE;
    end else if (state_q == S_CAPTURE) begin
      if (stop)
        state_d = S_DONE;
      else if (RING_MODE == 0 && wr && cap_count == CNT_LAST)
        state_d = S_DONE;
    end
  end

  assign capturing = (state_q == S_CAPTURE);
  assign cap_done  = (state_q == S_DONE);
  assign cap_start = overflow ? wr_ptr : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      cap_count <= '0;
      overflow  <= 1'b0;
      cap_ch    <= '0;
    end else if (start) begin
      wr_ptr    <= '0;
      cap_count <= '0;
      overflow  <= 1'b0;
      cap_ch    <= cmd_ch;
    end else if (wr) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (cap_count != CNT_MAX) cap_count <= cap_count + 1'b1;
      else                      overflow  <= 1'b1;
    end
  end

  // Buffer storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= buf_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[rd_add];
    end
  end

endmodule

// File: tb/tb_ultrasonic_ctrl_mc.sv
module tb_ultrasonic_ctrl_mc;
  localparam int NCH = 4, CH_W = 2, DAC_W = 12, DATA_W = 25, DEPTH = 128, ADDR_W = 7;
  localparam int LVL_MAX = (1 << DAC_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                cmd_valid, cmd_capture, rec_en, rd_en;
  logic [2:0]          cmd_op;
  logic [CH_W-1:0]     cmd_ch;
  logic [7:0]          cmd_amount;
  logic [DATA_W-1:0]   buf_in;
  logic [ADDR_W-1:0]   rd_add;

  // index 0: one-shot instance, index 1: ring instance
  logic                cmd_ready_o [2];
  logic [NCH*DAC_W-1:0] dac_out_o  [2];
  logic [NCH-1:0]      dac_on_o    [2];
  logic                capturing_o [2];
  logic                cap_done_o  [2];
  logic [CH_W-1:0]     cap_ch_o    [2];
  logic [ADDR_W:0]     cap_count_o [2];
  logic [ADDR_W-1:0]   cap_start_o [2];
  logic                overflow_o  [2];
  logic [DATA_W-1:0]   rd_data_o   [2];
  logic                rd_valid_o  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ultrasonic_ctrl_mc #(.NCH(NCH), .CH_W(CH_W), .DAC_W(DAC_W), .DATA_W(DATA_W),
                       .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RING_MODE(0)) u_oneshot (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_o[0]),
    .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_amount(cmd_amount), .cmd_capture(cmd_capture),
    .dac_out(dac_out_o[0]), .dac_on(dac_on_o[0]), .rec_en(rec_en), .buf_in(buf_in),
    .capturing(capturing_o[0]), .cap_done(cap_done_o[0]), .cap_ch(cap_ch_o[0]),
    .cap_count(cap_count_o[0]), .cap_start(cap_start_o[0]), .overflow(overflow_o[0]),
    .rd_en(rd_en), .rd_add(rd_add), .rd_data(rd_data_o[0]), .rd_valid(rd_valid_o[0]));

  ultrasonic_ctrl_mc #(.NCH(NCH), .CH_W(CH_W), .DAC_W(DAC_W), .DATA_W(DATA_W),
                       .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RING_MODE(1)) u_ring (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_o[1]),
    .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_amount(cmd_amount), .cmd_capture(cmd_capture),
    .dac_out(dac_out_o[1]), .dac_on(dac_on_o[1]), .rec_en(rec_en), .buf_in(buf_in),
    .capturing(capturing_o[1]), .cap_done(cap_done_o[1]), .cap_ch(cap_ch_o[1]),
    .cap_count(cap_count_o[1]), .cap_start(cap_start_o[1]), .overflow(overflow_o[1]),
    .rd_en(rd_en), .rd_add(rd_add), .rd_data(rd_data_o[1]), .rd_valid(rd_valid_o[1]));

  // Reference model: levels as integers, capture as a running sample total
  int                lvl [NCH];
  bit                on  [NCH];
  int                st    [2];   // 0 idle, 1 capturing, 2 done
  int                total [2];   // samples stored since last start
  int                cch   [2];
  logic [DATA_W-1:0] mmem  [2][DEPTH];
  logic [DATA_W-1:0] erd   [2];
  bit                erv;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin lvl[i] = 0; on[i] = 0; end
    for (int m = 0; m < 2; m++) begin st[m] = 0; total[m] = 0; cch[m] = 0; erd[m] = '0; end
    erv = 0;
  endtask

  // Applies the inputs present at the clock edge just taken.
  task automatic model_edge();
    bit acc, capt;
    int ch, amt;
    acc  = cmd_valid;
    capt = acc && cmd_capture;
    ch   = int'(cmd_ch);
    amt  = int'(cmd_amount);
    if (rd_en) for (int m = 0; m < 2; m++) erd[m] = mmem[m][rd_add];
    erv = rd_en;
    for (int m = 0; m < 2; m++) begin
      if (st[m] == 1 && rec_en && !capt) begin
        mmem[m][total[m] % DEPTH] = buf_in;
        total[m]++;
        if (m == 0 && total[m] == DEPTH) st[m] = 2;
      end
      if (acc && cmd_op == 3'd6 && st[m] == 1 && !capt) st[m] = 2;
      if (capt) begin st[m] = 1; total[m] = 0; cch[m] = ch; end
    end
    if (acc) begin
      case (cmd_op)
        3'd1: on[ch] = 1;
        3'd2: on[ch] = 0;
        3'd3: lvl[ch] = (lvl[ch] + amt > LVL_MAX) ? LVL_MAX : lvl[ch] + amt;
        3'd4: lvl[ch] = (lvl[ch] - amt < 0) ? 0 : lvl[ch] - amt;
        3'd5: lvl[ch] = amt;
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag, input int m, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst%0d observed=%0h expected=%0h", tag, m, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NCH*DAC_W-1:0] e_out;
    logic [NCH-1:0]       e_on;
    int cnt;
    bit ovf;
    e_out = '0;
    for (int i = 0; i < NCH; i++) begin
      e_out[i*DAC_W +: DAC_W] = on[i] ? DAC_W'(lvl[i]) : '0;
      e_on[i] = on[i];
    end
    for (int m = 0; m < 2; m++) begin
      cnt = (total[m] > DEPTH) ? DEPTH : total[m];
      ovf = total[m] > DEPTH;
      chk("cmd_ready", m, cmd_ready_o[m], rst_n ? 1 : cmd_ready_o[m]);
      chk("dac_out",   m, dac_out_o[m],   e_out);
      chk("dac_on",    m, dac_on_o[m],    e_on);
      chk("capturing", m, capturing_o[m], st[m] == 1);
      chk("cap_done",  m, cap_done_o[m],  st[m] == 2);
      chk("cap_ch",    m, cap_ch_o[m],    cch[m]);
      chk("cap_count", m, cap_count_o[m], cnt);
      chk("overflow",  m, overflow_o[m],  ovf);
      chk("cap_start", m, cap_start_o[m], ovf ? total[m] % DEPTH : 0);
      chk("rd_valid",  m, rd_valid_o[m],  erv);
      chk("rd_data",   m, rd_data_o[m],   erd[m]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic cmd(input logic [2:0] op, input int ch, input int amt, input bit cap);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_ch      = CH_W'(ch);
    cmd_amount  = 8'(amt);
    cmd_capture = cap;
    step();
    cmd_valid   = 1'b0;
    cmd_capture = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    cmd_valid = 0; cmd_capture = 0; cmd_op = '0; cmd_ch = '0; cmd_amount = '0;
    rec_en = 0; buf_in = '0; rd_en = 0; rd_add = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    #2 rst_n = 1'b1;
    step();
    chk("ready_after_reset", 0, cmd_ready_o[0], 1);

    // Channel 2 level and enable
    cmd(3'd5, 2, 200, 0);
    cmd(3'd1, 2, 0, 0);
    chk("dac_out_ch2", 0, dac_out_o[0], 48'd200 << 24);
    chk("dac_on_ch2",  0, dac_on_o[0],  4'b0100);

    // Channel 1 saturation at both ends, enable toggling keeps the level
    cmd(3'd1, 1, 0, 0);
    repeat (17) cmd(3'd3, 1, 255, 0);
    chk("sat_high", 0, dac_out_o[0][DAC_W +: DAC_W], 4095);
    repeat (17) cmd(3'd4, 1, 255, 0);
    chk("sat_low", 0, dac_out_o[0][DAC_W +: DAC_W], 0);
    cmd(3'd5, 1, 123, 0);
    cmd(3'd2, 1, 0, 0);
    chk("off_ch1", 0, dac_out_o[0][DAC_W +: DAC_W], 0);
    cmd(3'd1, 1, 0, 0);
    chk("on_ch1", 0, dac_out_o[0][DAC_W +: DAC_W], 123);

    // Random level commands
    repeat (60) cmd(3'($urandom_range(0, 7)), $urandom_range(0, NCH-1), $urandom_range(0, 255), 0);

    // Capture on ch3: one-shot fills at 128, ring runs to 200 samples
    cmd(3'd0, 3, 0, 1);
    for (int i = 0; i < 200; i++) begin
      rec_en = 1'b1; buf_in = DATA_W'(i);
      step();
    end
    rec_en = 1'b0;
    chk("oneshot_done", 0, cap_done_o[0], 1);
    chk("oneshot_ch",   0, cap_ch_o[0], 3);
    chk("ring_count",   1, cap_count_o[1], 128);
    chk("ring_start",   1, cap_start_o[1], 72);
    chk("ring_ovf",     1, overflow_o[1], 1);
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1'b1; rd_add = ADDR_W'(a);
      step();
      if (a == 72) chk("ring_mem72", 1, rd_data_o[1], 72);
    end
    rd_en = 1'b0;
    step();
    cmd(3'd6, 0, 0, 0);
    chk("ring_stop", 1, cap_done_o[1], 1);

    // Restart mid-run; INC riding along with the restart
    cmd(3'd0, 1, 0, 1);
    for (int i = 0; i < 50; i++) begin
      rec_en = 1'b1; buf_in = DATA_W'($urandom);
      step();
    end
    buf_in = DATA_W'($urandom);
    cmd(3'd3, 0, 10, 1);
    chk("restart_count", 0, cap_count_o[0], 0);
    for (int i = 0; i < 5; i++) begin
      buf_in = DATA_W'($urandom);
      step();
    end
    // Collision on address 5: read-first, then the new value
    buf_in = DATA_W'(25'h1ABCDE);
    rd_en = 1'b1; rd_add = ADDR_W'(5);
    step();
    rec_en = 1'b0;
    step();
    chk("collision_new", 0, rd_data_o[0], 25'h1ABCDE);
    rd_en = 1'b0;
    step();

    // Random mixed traffic
    repeat (400) begin
      cmd_valid   = ($urandom_range(0, 3) != 0);
      cmd_op      = 3'($urandom_range(0, 7));
      cmd_ch      = CH_W'($urandom_range(0, NCH-1));
      cmd_amount  = 8'($urandom);
      cmd_capture = ($urandom_range(0, 39) == 0);
      rec_en      = ($urandom_range(0, 3) != 0);
      buf_in      = DATA_W'($urandom);
      rd_en       = $urandom_range(0, 1);
      rd_add      = ADDR_W'($urandom);
      step();
    end
    cmd_valid = 0; cmd_capture = 0; rd_en = 0;

    // Asynchronous reset in the middle of a capture
    cmd(3'd0, 2, 0, 1);
    rec_en = 1'b1;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clk);
    #1 check_all();
    rec_en = 1'b0;
    #2 rst_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
